sdram_device_responder: RTL and testbench
=========================================

// Module: sdram_device_responder
// PURPOSE
//  Device-side responder for the SDRAM command interface driven by our SDRAM controller.
//  - Decodes cle/cs/ras/cas/we/ba/a/dqm issued each clock.
//  - Tracks open rows in 4 banks and checks protocol and timing.
//  - Stores write data; returns read data after CAS_LAT cycles.
//  Used as the memory endpoint in the user-project simulation and FPGA bring-up.
// PARAMETERS
//  CAS_LAT  1   edges from READ sample to sdram_dqi update (legal 1..3)
//  T_RCD    3   min cycles from ACTIVE to READ/WRITE on the same bank
//  T_RP     3   min cycles from PRECHARGE to ACTIVE on the affected bank(s)
//  T_RFC    7   min cycles from REFRESH to any non-NOP command
//  MEM_AW   10  backing array address width, 2**MEM_AW 32-bit words (MEM_AW >= 9)
// PORTS
//  clk          in   1   clock; all inputs sampled on rising edge
//  rst          in   1   async active-high reset
//  sdram_cle    in   1   clock enable; 0 = all commands treated as NOP
//  sdram_cs     in   1   cmd[3]; 1 = deselected (NOP)
//  sdram_ras    in   1   cmd[2]
//  sdram_cas    in   1   cmd[1]
//  sdram_we     in   1   cmd[0]
//  sdram_dqm    in   1   data mask: write suppressed / read returns 0
//  sdram_ba     in   2   bank address
//  sdram_a      in   13  row on ACTIVE; col = a[5:0] on READ/WRITE; a[10]=all on PRECHARGE
//  sdram_dqo    in   32  write data, valid in the WRITE command cycle
//  sdram_dqi    out  32  read data to controller
//  bank_open    out  4   per-bank row-open status
//  err_proto    out  1   sticky: protocol error
//  err_timing   out  1   sticky: timing violation
//  refresh_cnt  out  16  count of REFRESH commands accepted (wraps 0xFFFF->0)
// BEHAVIOUR
//  - Reset (async): sdram_dqi=0, bank_open=0, err_*=0, refresh_cnt=0.
//    Reset also clears the read pipeline and all timers. Array contents are retained.
//  - Decode cmd={cs,ras,cas,we} on each edge:
//    1000/0111=NOP, 0011=ACTIVE, 0101=READ, 0100=WRITE, 0010=PRECHARGE, 0001=REFRESH,
//    0000=LMR (accepted, ignored), 0110=TERMINATE (ignored). cle=0 forces NOP.
//  - Per-bank state: IDLE or ACTIVE(row). Each bank has a down-counter for tRCD/tRP.
//    One global counter for tRFC. A counter loads T_x-1 at its command and decrements to 0.
//  - ACTIVE: bank IDLE -> ACTIVE, latch row. On an open bank: err_proto; row is replaced.
//    Bank tRP counter != 0: err_timing; command still executes.
//  - PRECHARGE: a[10]=1 closes all banks, else bank ba only. Closing an already-IDLE bank is legal.
//  - READ/WRITE word index = {row[MEM_AW-9:0], ba, a[5:0]}.
//    Bank IDLE: err_proto; write dropped, read still returns 0 with normal latency.
//    Bank tRCD counter != 0: err_timing; command still executes.
//  - WRITE: if dqm=0, the array is written at this edge. A READ on the next edge returns the new word.
//  - READ: array read at the sample edge (N) and carried down a CAS_LAT-deep valid/data shift pipeline.
//    sdram_dqi updates at edge N+CAS_LAT and holds until the next read result.
//    dqm=1 at READ -> result 0. Back-to-back READs every cycle give one result per cycle, in order.
//  - REFRESH: any bank open -> err_proto. Otherwise refresh_cnt+1 and the tRFC counter loads.
//    Any non-NOP command while the tRFC counter != 0 -> err_timing; that command is executed anyway.
//  - Only one command per cycle exists.
//    A READ sampled on the same edge that a pipeline result retires is legal; both proceed.
//  - err_* stay set until rst.
// TESTING
//  1. ACT b0 row5; wait 3; WRITE col3 0xDEADBEEF; READ col3 -> sdram_dqi=0xDEADBEEF 1 edge after READ sample; err_*=0.
//  2. ACT b1 row2; READ 1 cycle later -> err_timing=1. Data is still returned; bank_open=4'b0010.
//  3. ACT b0; REFRESH with no PRECHARGE -> err_proto=1, refresh_cnt stays 0.
//     PRECHARGE a[10]=1, wait 3, REFRESH -> refresh_cnt=1, bank_open=0.
//  4. WRITE 0x11111111 with dqm=1 over stored 0xA5A5A5A5 -> READ returns 0xA5A5A5A5. READ with dqm=1 -> 0.
//  5. cle=0 while cmd=ACTIVE -> bank_open unchanged, no errors.
//     READ to a closed bank -> err_proto=1, sdram_dqi=0.
//  6. Issue READ, assert rst before data is due -> sdram_dqi stays 0, bank_open=0.
//     After release, ACT+READ of the same address returns the pre-reset word.

Source files
------------

// File: rtl/sdram_device_responder.sv
// Device-side SDRAM endpoint: decodes controller commands, tracks per-bank open rows and
// tRCD/tRP/tRFC timing, flags sticky protocol/timing errors, and serves data from a word array.
module sdram_device_responder #(
   parameter int CAS_LAT = 1,
   parameter int T_RCD   = 3,
   parameter int T_RP    = 3,
   parameter int T_RFC   = 7,
   parameter int MEM_AW  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sdram_cle,
   input  logic        sdram_cs,
   input  logic        sdram_ras,
   input  logic        sdram_cas,
   input  logic        sdram_we,
   input  logic        sdram_dqm,
   input  logic [1:0]  sdram_ba,
   input  logic [12:0] sdram_a,
   input  logic [31:0] sdram_dqo,
   output logic [31:0] sdram_dqi,
   output logic [3:0]  bank_open,
   output logic        err_proto,
   output logic        err_timing,
   output logic [15:0] refresh_cnt
);

   localparam int RW = MEM_AW - 8;
   localparam logic [7:0] RCD_LOAD = 8'(T_RCD - 1);
   localparam logic [7:0] RP_LOAD  = 8'(T_RP - 1);
   localparam logic [7:0] RFC_LOAD = 8'(T_RFC - 1);

   typedef enum logic [2:0] {
      CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF, CMD_LMR, CMD_TERM
   } cmd_e;

   cmd_e cmd;

   logic [3:0]          bankOpen_q, bankOpen_d;
   logic [3:0][RW-1:0]  rowAddr_q, rowAddr_d;
   logic [3:0][7:0]     bankCnt_q, bankCnt_d;
   logic [7:0]          rfcCnt_q, rfcCnt_d;
   logic                errProto_q, errProto_d;
   logic                errTiming_q, errTiming_d;
   logic [15:0]         refreshCnt_q, refreshCnt_d;

   logic [31:0]               memArray_q [2**MEM_AW];
   logic [MEM_AW-1:0]         wordAddr;
   logic                      memWrEn;
   logic                      rdStart;
   logic [31:0]               rdWord;
   logic [CAS_LAT-1:0]        pipeValid_q;
   logic [CAS_LAT-1:0][31:0]  pipeData_q;
   logic [31:0]               dqi_q;
   logic                      unusedAddrBits;

   // A deselected chip or a low clock enable both collapse to NOP.
   always_comb begin
      cmd = CMD_NOP;
      if (sdram_cle && !sdram_cs) begin
         case ({sdram_ras, sdram_cas, sdram_we})
            3'b011:  cmd = CMD_ACT;
            3'b101:  cmd = CMD_READ;
            3'b100:  cmd = CMD_WRITE;
            3'b010:  cmd = CMD_PRE;
            3'b001:  cmd = CMD_REF;
            3'b000:  cmd = CMD_LMR;
            3'b110:  cmd = CMD_TERM;
            default: cmd = CMD_NOP;
         endcase
      end
   end

   // Each bank counter is loaded by ACTIVE (tRCD) or PRECHARGE (tRP); which one applies is
   // implied by the bank state, since only PRECHARGE closes a bank and only ACTIVE opens it.
   always_comb begin
      bankOpen_d   = bankOpen_q;
      rowAddr_d    = rowAddr_q;
      errProto_d   = errProto_q;
      errTiming_d  = errTiming_q;
      refreshCnt_d = refreshCnt_q;
      rfcCnt_d     = (rfcCnt_q != 8'd0) ? rfcCnt_q - 8'd1 : 8'd0;
      for (int i = 0; i < 4; i++) begin
         bankCnt_d[i] = (bankCnt_q[i] != 8'd0) ? bankCnt_q[i] - 8'd1 : 8'd0;
      end
      if (cmd != CMD_NOP && rfcCnt_q != 8'd0) begin
         errTiming_d = 1'b1;
      end
      case (cmd)
         CMD_ACT: begin
            if (bankOpen_q[sdram_ba]) begin
               errProto_d = 1'b1;
            end else if (bankCnt_q[sdram_ba] != 8'd0) begin
               errTiming_d = 1'b1;
            end
            bankOpen_d[sdram_ba] = 1'b1;
            rowAddr_d[sdram_ba]  = sdram_a[RW-1:0];
            bankCnt_d[sdram_ba]  = RCD_LOAD;
         end
         CMD_READ, CMD_WRITE: begin
            if (!bankOpen_q[sdram_ba]) begin
               errProto_d = 1'b1;
            end else if (bankCnt_q[sdram_ba] != 8'd0) begin
               errTiming_d = 1'b1;
            end
         end
         CMD_PRE: begin
            for (int i = 0; i < 4; i++) begin
               if (sdram_a[10] || sdram_ba == 2'(i)) begin
                  bankOpen_d[i] = 1'b0;
                  bankCnt_d[i]  = RP_LOAD;
               end
            end
         end
         CMD_REF: begin
            if (|bankOpen_q) begin
               errProto_d = 1'b1;
            end else begin
               refreshCnt_d = refreshCnt_q + 16'd1;
               rfcCnt_d     = RFC_LOAD;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bankOpen_q   <= '0;
         rowAddr_q    <= '0;
         bankCnt_q    <= '0;
         rfcCnt_q     <= '0;
         errProto_q   <= 1'b0;
         errTiming_q  <= 1'b0;
         refreshCnt_q <= '0;
      end else begin
         bankOpen_q   <= bankOpen_d;
         rowAddr_q    <= rowAddr_d;
         bankCnt_q    <= bankCnt_d;
         rfcCnt_q     <= rfcCnt_d;
         errProto_q   <= errProto_d;
         errTiming_q  <= errTiming_d;
         refreshCnt_q <= refreshCnt_d;
      end
   end

   assign wordAddr = {rowAddr_q[sdram_ba], sdram_ba, sdram_a[5:0]};
   assign memWrEn  = (cmd == CMD_WRITE) && bankOpen_q[sdram_ba] && !sdram_dqm;
   assign rdStart  = (cmd == CMD_READ);
   assign rdWord   = (bankOpen_q[sdram_ba] && !sdram_dqm) ? memArray_q[wordAddr] : 32'd0;
   assign unusedAddrBits = ^sdram_a;

   // The array has no reset so its contents survive rst.
   always_ff @(posedge clk) begin
      if (memWrEn) begin
         memArray_q[wordAddr] <= sdram_dqo;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipeValid_q <= '0;
         pipeData_q  <= '0;
         dqi_q       <= '0;
      end else begin
         pipeValid_q[0] <= rdStart;
         pipeData_q[0]  <= rdWord;
         for (int k = 1; k < CAS_LAT; k++) begin
            pipeValid_q[k] <= pipeValid_q[k-1];
            pipeData_q[k]  <= pipeData_q[k-1];
         end
         if (pipeValid_q[CAS_LAT-1]) begin
            dqi_q <= pipeData_q[CAS_LAT-1];
         end
      end
   end

   assign sdram_dqi   = dqi_q;
   assign bank_open   = bankOpen_q;
   assign err_proto   = errProto_q;
   assign err_timing  = errTiming_q;
   assign refresh_cnt = refreshCnt_q;

endmodule

// File: tb/tb_sdram_device_responder.sv
// Directed and randomized checks of sdram_device_responder against a cycle-stamped
// reference model (timestamps of last ACT/PRE/REF instead of down-counters).
module tb_sdram_device_responder;

   localparam int CAS_LAT = 1;
   localparam int T_RCD   = 3;
   localparam int T_RP    = 3;
   localparam int T_RFC   = 7;
   localparam int MEM_AW  = 10;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;
   localparam logic [3:0] C_TRM = 4'b0110;

   logic        clk, rst;
   logic        sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we, sdram_dqm;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_a;
   logic [31:0] sdram_dqo, sdram_dqi;
   logic [3:0]  bank_open;
   logic        err_proto, err_timing;
   logic [15:0] refresh_cnt;

   typedef struct {
      int          due;
      logic [31:0] val;
      bit          known;
   } rdItem_t;

   bit          mOpen [4];
   logic [12:0] mRow [4];
   int          mLastAct [4];
   int          mLastPre [4];
   int          mLastRef;
   logic        mErrP, mErrT;
   logic [15:0] mRefCnt;
   logic [31:0] mDqi;
   bit          mDqiKnown;
   logic [31:0] memModel [1 << MEM_AW];
   bit          memKnown [1 << MEM_AW];
   rdItem_t     pending [$];
   int          curCycle;
   int          checks;
   int          failures;

   sdram_device_responder #(
      .CAS_LAT(CAS_LAT), .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .MEM_AW(MEM_AW)
   ) dut (
      .clk(clk), .rst(rst), .sdram_cle(sdram_cle), .sdram_cs(sdram_cs),
      .sdram_ras(sdram_ras), .sdram_cas(sdram_cas), .sdram_we(sdram_we),
      .sdram_dqm(sdram_dqm), .sdram_ba(sdram_ba), .sdram_a(sdram_a),
      .sdram_dqo(sdram_dqo), .sdram_dqi(sdram_dqi), .bank_open(bank_open),
      .err_proto(err_proto), .err_timing(err_timing), .refresh_cnt(refresh_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int wordIndex(input int bank, input logic [12:0] row, input logic [12:0] a);
      return (int'(row) % (1 << (MEM_AW - 8))) * 256 + bank * 64 + (int'(a) % 64);
   endfunction

   task automatic resetModel();
      for (int i = 0; i < 4; i++) begin
         mOpen[i]    = 1'b0;
         mLastAct[i] = -1000;
         mLastPre[i] = -1000;
      end
      mLastRef  = -1000;
      mErrP     = 1'b0;
      mErrT     = 1'b0;
      mRefCnt   = 16'd0;
      mDqi      = 32'd0;
      mDqiKnown = 1'b1;
      pending.delete();
   endtask

   task automatic modelStep(input logic cle, input logic [3:0] cmd, input logic [1:0] ba,
                            input logic [12:0] a, input logic dqm, input logic [31:0] dq);
      int b;
      int idx;
      rdItem_t item;
      b   = int'(ba);
      idx = 0;
      if (!cle || cmd[3] || cmd == C_NOP) return;
      if (curCycle - mLastRef < T_RFC) mErrT = 1'b1;
      case (cmd)
         C_ACT: begin
            if (mOpen[b]) mErrP = 1'b1;
            else if (curCycle - mLastPre[b] < T_RP) mErrT = 1'b1;
            mOpen[b]    = 1'b1;
            mRow[b]     = a;
            mLastAct[b] = curCycle;
         end
         C_RD, C_WR: begin
            if (!mOpen[b]) begin
               mErrP = 1'b1;
            end else begin
               if (curCycle - mLastAct[b] < T_RCD) mErrT = 1'b1;
               idx = wordIndex(b, mRow[b], a);
            end
            if (cmd == C_WR) begin
               if (mOpen[b] && !dqm) begin
                  memModel[idx] = dq;
                  memKnown[idx] = 1'b1;
               end
            end else begin
               item.due   = curCycle + CAS_LAT;
               item.val   = 32'd0;
               item.known = 1'b1;
               if (mOpen[b] && !dqm) begin
                  item.val   = memModel[idx];
                  item.known = memKnown[idx];
               end
               pending.push_back(item);
            end
         end
         C_PRE: begin
            for (int i = 0; i < 4; i++) begin
               if (a[10] || i == b) begin
                  mOpen[i]    = 1'b0;
                  mLastPre[i] = curCycle;
               end
            end
         end
         C_REF: begin
            if (mOpen[0] || mOpen[1] || mOpen[2] || mOpen[3]) begin
               mErrP = 1'b1;
            end else begin
               mRefCnt  = mRefCnt + 16'd1;
               mLastRef = curCycle;
            end
         end
         default: ;
      endcase
   endtask

   task automatic checkValue32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [3:0] expOpen;
      expOpen = {mOpen[3], mOpen[2], mOpen[1], mOpen[0]};
      if (mDqiKnown) checkValue32({tag, ".dqi"}, sdram_dqi, mDqi);
      checkValue32({tag, ".bank_open"}, {28'd0, bank_open}, {28'd0, expOpen});
      checkValue32({tag, ".err_proto"}, {31'd0, err_proto}, {31'd0, mErrP});
      checkValue32({tag, ".err_timing"}, {31'd0, err_timing}, {31'd0, mErrT});
      checkValue32({tag, ".refresh_cnt"}, {16'd0, refresh_cnt}, {16'd0, mRefCnt});
   endtask

   task automatic applyStimulus(input string tag, input logic cle, input logic [3:0] cmd,
                                input logic [1:0] ba, input logic [12:0] a, input logic dqm,
                                input logic [31:0] dq);
      @(negedge clk);
      sdram_cle = cle;
      {sdram_cs, sdram_ras, sdram_cas, sdram_we} = cmd;
      sdram_ba  = ba;
      sdram_a   = a;
      sdram_dqm = dqm;
      sdram_dqo = dq;
      curCycle++;
      modelStep(cle, cmd, ba, a, dqm, dq);
      while (pending.size() > 0 && pending[0].due <= curCycle) begin
         mDqi      = pending[0].val;
         mDqiKnown = pending[0].known;
         pending.delete(0);
      end
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   task automatic nop(input string tag);
      applyStimulus(tag, 1'b1, C_NOP, 2'd0, 13'd0, 1'b0, 32'd0);
   endtask

   task automatic doReset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      sdram_cle = 1'b1;
      {sdram_cs, sdram_ras, sdram_cas, sdram_we} = C_NOP;
      resetModel();
      @(posedge clk);
      #1;
      checkOutput(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic        rCle, rDqm;
      logic [3:0]  rCmd;
      logic [1:0]  rBa;
      logic [12:0] rA;
      logic [31:0] rDq;
      int          r;
      checks   = 0;
      failures = 0;
      curCycle = 0;
      rst       = 1'b1;
      sdram_cle = 1'b1;
      {sdram_cs, sdram_ras, sdram_cas, sdram_we} = C_NOP;
      sdram_dqm = 1'b0;
      sdram_ba  = 2'd0;
      sdram_a   = 13'd0;
      sdram_dqo = 32'd0;
      for (int i = 0; i < (1 << MEM_AW); i++) begin
         memModel[i] = 32'd0;
         memKnown[i] = 1'b0;
      end
      for (int i = 0; i < 4; i++) mRow[i] = 13'd0;
      resetModel();

      // Basic write then read with one-edge CAS latency.
      doReset("t1_reset");
      checkValue32("t1_reset_dqi", sdram_dqi, 32'd0);
      checkValue32("t1_reset_refcnt", {16'd0, refresh_cnt}, 32'd0);
      applyStimulus("t1_act", 1'b1, C_ACT, 2'd0, 13'd5, 1'b0, 32'd0);
      nop("t1_w1");
      nop("t1_w2");
      applyStimulus("t1_wr", 1'b1, C_WR, 2'd0, 13'd3, 1'b0, 32'hDEADBEEF);
      applyStimulus("t1_rd", 1'b1, C_RD, 2'd0, 13'd3, 1'b0, 32'd0);
      checkValue32("t1_dqi_not_yet", sdram_dqi, 32'd0);
      nop("t1_data");
      checkValue32("t1_dqi", sdram_dqi, 32'hDEADBEEF);
      checkValue32("t1_errs", {30'd0, err_proto, err_timing}, 32'd0);

      // tRCD violation still returns data.
      doReset("t2_reset");
      applyStimulus("t2_act", 1'b1, C_ACT, 2'd1, 13'd2, 1'b0, 32'd0);
      nop("t2_w1");
      nop("t2_w2");
      applyStimulus("t2_wr", 1'b1, C_WR, 2'd1, 13'd0, 1'b0, 32'h12345678);
      applyStimulus("t2_pre", 1'b1, C_PRE, 2'd1, 13'd0, 1'b0, 32'd0);
      nop("t2_w3");
      nop("t2_w4");
      applyStimulus("t2_act2", 1'b1, C_ACT, 2'd1, 13'd2, 1'b0, 32'd0);
      applyStimulus("t2_rd", 1'b1, C_RD, 2'd1, 13'd0, 1'b0, 32'd0);
      checkValue32("t2_err_timing", {31'd0, err_timing}, 32'd1);
      checkValue32("t2_bank_open", {28'd0, bank_open}, 32'h2);
      nop("t2_data");
      checkValue32("t2_dqi", sdram_dqi, 32'h12345678);

      // Refresh rules and the tRFC window boundary.
      doReset("t3_reset");
      applyStimulus("t3_act", 1'b1, C_ACT, 2'd0, 13'd0, 1'b0, 32'd0);
      nop("t3_w1");
      nop("t3_w2");
      applyStimulus("t3_ref_bad", 1'b1, C_REF, 2'd0, 13'd0, 1'b0, 32'd0);
      checkValue32("t3_err_proto", {31'd0, err_proto}, 32'd1);
      checkValue32("t3_refcnt0", {16'd0, refresh_cnt}, 32'd0);
      applyStimulus("t3_pre_all", 1'b1, C_PRE, 2'd2, 13'h400, 1'b0, 32'd0);
      nop("t3_w3");
      nop("t3_w4");
      applyStimulus("t3_ref", 1'b1, C_REF, 2'd0, 13'd0, 1'b0, 32'd0);
      checkValue32("t3_refcnt1", {16'd0, refresh_cnt}, 32'd1);
      checkValue32("t3_bank_open", {28'd0, bank_open}, 32'd0);
      for (int i = 0; i < T_RFC - 1; i++) nop("t3_rfc_wait");
      applyStimulus("t3_act_after_rfc", 1'b1, C_ACT, 2'd1, 13'd0, 1'b0, 32'd0);
      checkValue32("t3_no_rfc_err", {31'd0, err_timing}, 32'd0);
      applyStimulus("t3_pre_all2", 1'b1, C_PRE, 2'd0, 13'h400, 1'b0, 32'd0);
      nop("t3_w5");
      nop("t3_w6");
      applyStimulus("t3_ref2", 1'b1, C_REF, 2'd0, 13'd0, 1'b0, 32'd0);
      applyStimulus("t3_lmr", 1'b1, C_LMR, 2'd0, 13'd0, 1'b0, 32'd0);
      checkValue32("t3_rfc_err", {31'd0, err_timing}, 32'd1);
      checkValue32("t3_refcnt2", {16'd0, refresh_cnt}, 32'd2);

      // Data mask on write and on read.
      doReset("t4_reset");
      applyStimulus("t4_act", 1'b1, C_ACT, 2'd2, 13'd1, 1'b0, 32'd0);
      nop("t4_w1");
      nop("t4_w2");
      applyStimulus("t4_wr", 1'b1, C_WR, 2'd2, 13'd9, 1'b0, 32'hA5A5A5A5);
      applyStimulus("t4_wr_masked", 1'b1, C_WR, 2'd2, 13'd9, 1'b1, 32'h11111111);
      applyStimulus("t4_rd", 1'b1, C_RD, 2'd2, 13'd9, 1'b0, 32'd0);
      nop("t4_data");
      checkValue32("t4_dqi", sdram_dqi, 32'hA5A5A5A5);
      applyStimulus("t4_rd_masked", 1'b1, C_RD, 2'd2, 13'd9, 1'b1, 32'd0);
      nop("t4_data2");
      checkValue32("t4_dqi_masked", sdram_dqi, 32'd0);

      // Clock-enable gating, then a read of a closed bank.
      applyStimulus("t5_cle0", 1'b0, C_ACT, 2'd3, 13'd7, 1'b0, 32'd0);
      checkValue32("t5_bank_open", {28'd0, bank_open}, 32'h4);
      checkValue32("t5_errs", {30'd0, err_proto, err_timing}, 32'd0);
      applyStimulus("t5_rd_open", 1'b1, C_RD, 2'd2, 13'd9, 1'b0, 32'd0);
      applyStimulus("t5_rd_closed", 1'b1, C_RD, 2'd3, 13'd0, 1'b0, 32'd0);
      checkValue32("t5_err_proto", {31'd0, err_proto}, 32'd1);
      checkValue32("t5_dqi_prev", sdram_dqi, 32'hA5A5A5A5);
      nop("t5_data");
      checkValue32("t5_dqi_closed", sdram_dqi, 32'd0);

      // Reset while a read is in flight; array contents survive.
      applyStimulus("t6_rd", 1'b1, C_RD, 2'd2, 13'd9, 1'b0, 32'd0);
      rst = 1'b1;
      resetModel();
      @(posedge clk);
      #1;
      checkOutput("t6_in_reset");
      checkValue32("t6_dqi", sdram_dqi, 32'd0);
      checkValue32("t6_bank_open", {28'd0, bank_open}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      {sdram_cs, sdram_ras, sdram_cas, sdram_we} = C_NOP;
      applyStimulus("t6_act", 1'b1, C_ACT, 2'd2, 13'd1, 1'b0, 32'd0);
      nop("t6_w1");
      nop("t6_w2");
      applyStimulus("t6_rd2", 1'b1, C_RD, 2'd2, 13'd9, 1'b0, 32'd0);
      nop("t6_data");
      checkValue32("t6_dqi_kept", sdram_dqi, 32'hA5A5A5A5);

      // Fill the addresses the random phase can reach, using legal timing.
      doReset("pf_reset");
      for (int row = 0; row < 2; row++) begin
         for (int b = 0; b < 4; b++) applyStimulus("pf_act", 1'b1, C_ACT, 2'(b), 13'(row), 1'b0, 32'd0);
         for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 8; c++) begin
               applyStimulus("pf_wr", 1'b1, C_WR, 2'(b), 13'(c), 1'b0, $urandom);
            end
         end
         applyStimulus("pf_pre", 1'b1, C_PRE, 2'd0, 13'h400, 1'b0, 32'd0);
         nop("pf_w1");
         nop("pf_w2");
      end

      for (int blk = 0; blk < 6; blk++) begin
         doReset("rnd_reset");
         for (int n = 0; n < 60; n++) begin
            r    = $urandom_range(0, 99);
            rCle = 1'b1;
            rDqm = ($urandom_range(0, 9) == 0);
            rA   = 13'($urandom) & 13'h1FC5;
            rBa  = 2'($urandom);
            rDq  = $urandom;
            if (r < 15)      rCmd = C_ACT;
            else if (r < 40) rCmd = C_RD;
            else if (r < 60) rCmd = C_WR;
            else if (r < 70) rCmd = C_PRE;
            else if (r < 74) rCmd = C_REF;
            else if (r < 76) rCmd = C_LMR;
            else if (r < 78) rCmd = C_TRM;
            else if (r < 84) rCmd = {1'b1, 3'($urandom)};
            else if (r < 90) begin
               rCle = 1'b0;
               rCmd = 4'($urandom);
            end else         rCmd = C_NOP;
            applyStimulus("rnd", rCle, rCmd, rBa, rA, rDqm, rDq);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
